// File: rtl/bram_rd_pkg.sv
// Shared types and constants for the BRAM read-stream front end.
// Optional feature macro used by this slice: BRAM_RD_STRIDE_EN
// (adds a per-burst word stride input to bram_rd_stream).
package bram_rd_pkg;

    // Burst controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/bram_rd_fifo.sv
// Small synchronous FIFO that buffers BRAM read words (plus their last flag)
// in front of the output stream. DEPTH must be a power of two, >= 2.
// Push while full and pop while empty are ignored.
module bram_rd_fifo
    import bram_rd_pkg::*;
#(
    parameter  int WIDTH = 33,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic [PTR_W:0]   o_count
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A simultaneous pop frees a slot, so a push is still legal when full
    assign w_do_pop  = i_pop && (r_count != {(PTR_W + 1){1'b0}});
    assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

    // Storage array and write pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= {PTR_W{1'b0}};
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
            r_wr_ptr        <= r_wr_ptr + PTR_ONE;
        end else begin
            r_wr_ptr <= r_wr_ptr;
        end
    end

    // Read pointer and occupancy count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {(PTR_W + 1){1'b0}};
        end else begin
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == {(PTR_W + 1){1'b0}});
    assign o_count = r_count;

endmodule

// File: rtl/bram_rd_stream.sv
// Read-side front end for the feature-map BRAM: on start it issues a burst of
// word reads (byte addressed, 1-cycle read latency) and returns the words as a
// valid/ready stream through a small FIFO. Reads are only issued when the FIFO
// has room for them plus any read still in flight, so nothing is ever dropped.
// Optional feature macro: BRAM_RD_STRIDE_EN adds a 'stride' input (in words).
module bram_rd_stream
    import bram_rd_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    output logic [3:0]        bram_wen,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready
`ifdef BRAM_RD_STRIDE_EN
    ,
    input  logic [LEN_W-1:0]  stride
`endif
);

    localparam int              CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [LEN_W:0]  SCHED_ONE = (LEN_W + 1)'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LEN_W:0]      r_len;
    logic [LEN_W:0]      r_sched;
    logic [LEN_W:0]      w_len_eff;
    logic [LEN_W:0]      w_sched_base;
    logic [ADDR_W-1:0]   r_bram_addr;
    logic [ADDR_W-1:0]   r_stride_bytes;
    logic [ADDR_W-1:0]   w_stride_bytes_in;
    logic [ADDR_W-1:0]   w_base_aligned;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [LEN_W-1:0]    w_stride_words;
    logic                r_bram_en;
    logic                r_rd_vld;
    logic                r_rd_last;
    logic                r_busy;
    logic                r_done;
    logic                w_en_nxt;
    logic                w_last_issue;
    logic                w_pop;
    logic                w_fire_last;
    logic                w_fifo_empty;
    logic [CNT_W-1:0]    w_fifo_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_credit;
    logic [DATA_W:0]     w_fifo_dout;

`ifdef BRAM_RD_STRIDE_EN
    assign w_stride_words = stride;
`else
    assign w_stride_words = LEN_W'(1);
`endif

    assign w_stride_bytes_in = ADDR_W'(w_stride_words) << WORD_SHIFT;
    assign w_base_aligned    = base_addr & ~(ADDR_W'(WORD_BYTES - 1));

    // r_sched counts reads issued so far including the one on the port now
    assign w_last_issue = r_bram_en && (r_sched == r_len);
    assign w_pop        = !w_fifo_empty && m_ready;
    assign w_fire_last  = w_pop && w_fifo_dout[DATA_W];

    // Next-state logic for the burst controller
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (len != {LEN_W{1'b0}}) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_last_issue) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                if (w_fire_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Decide next cycle's read: the FIFO occupancy it will see plus the read
    // currently on the port (in flight then) must leave room for one more
    always_comb begin
        w_len_eff    = r_len;
        w_sched_base = r_sched;
        w_addr_nxt   = r_bram_addr + r_stride_bytes;
        if (r_state == IDLE) begin
            w_len_eff    = {1'b0, len};
            w_sched_base = {(LEN_W + 1){1'b0}};
            w_addr_nxt   = w_base_aligned;
        end else begin
            w_len_eff    = r_len;
            w_sched_base = r_sched;
            w_addr_nxt   = r_bram_addr + r_stride_bytes;
        end
        w_cnt_nxt = w_fifo_cnt + {{(CNT_W - 1){1'b0}}, r_rd_vld}
                               - {{(CNT_W - 1){1'b0}}, w_pop};
        w_credit  = w_cnt_nxt + {{(CNT_W - 1){1'b0}}, r_bram_en};
        w_en_nxt  = (w_state_nxt == RUN) && (w_sched_base < w_len_eff)
                    && (w_credit < DEPTH_CNT);
    end

    // State register and burst parameters sampled with an accepted start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_len          <= {(LEN_W + 1){1'b0}};
            r_stride_bytes <= {ADDR_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && start) begin
                r_len          <= {1'b0, len};
                r_stride_bytes <= w_stride_bytes_in;
            end else begin
                r_len          <= r_len;
                r_stride_bytes <= r_stride_bytes;
            end
        end
    end

    // BRAM port: registered enable/address and the issue counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bram_en   <= 1'b0;
            r_bram_addr <= {ADDR_W{1'b0}};
            r_sched     <= {(LEN_W + 1){1'b0}};
        end else begin
            r_bram_en <= w_en_nxt;
            if (w_en_nxt) begin
                r_bram_addr <= w_addr_nxt;
                r_sched     <= w_sched_base + SCHED_ONE;
            end else begin
                r_bram_addr <= r_bram_addr;
                r_sched     <= r_sched;
            end
        end
    end

    // Track the read in flight so its data is captured exactly one cycle later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
        end else begin
            r_rd_vld  <= r_bram_en;
            r_rd_last <= w_last_issue;
        end
    end

    // Status outputs registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            r_done <= (w_state_nxt == DONE);
        end
    end

    bram_rd_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_rd_vld),
        .i_din   ({r_rd_last, bram_dout}),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_cnt)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign bram_en   = r_bram_en;
    assign bram_addr = r_bram_addr;
    assign bram_wen  = 4'b0000;
    assign bram_din  = {DATA_W{1'b0}};
    assign m_valid   = !w_fifo_empty;
    assign m_data    = w_fifo_dout[DATA_W-1:0];
    assign m_last    = !w_fifo_empty && w_fifo_dout[DATA_W];

endmodule

// File: tb/tb_bram_rd_stream.sv
// Directed self-checking bench for bram_rd_stream with a behavioural BRAM
// (en-gated, 1-cycle read, mem[i] = i*3). Build with +define+BRAM_RD_STRIDE_EN
// to also exercise the stride port.
module tb_bram_rd_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic [15:0] len = 16'd0;
    logic        busy, done, bram_en, m_valid, m_last;
    logic [31:0] bram_addr, bram_din, m_data;
    logic [3:0]  bram_wen;
    logic [31:0] bram_dout = 32'hDEAD_BEEF;
    logic        m_ready = 1'b1;
    logic [15:0] stride = 16'd1;

    int n_checks = 0;
    int n_fail   = 0;

    bram_rd_stream dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .bram_addr (bram_addr),
        .bram_en   (bram_en),
        .bram_wen  (bram_wen),
        .bram_din  (bram_din),
        .bram_dout (bram_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready)
`ifdef BRAM_RD_STRIDE_EN
        ,
        .stride    (stride)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural BRAM
    logic [31:0] mem [0:255];
    always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr[9:2]];

    // Cycle index and monitor (samples on the falling edge)
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] addr_q[$];
    int          addr_cyc_q[$];
    logic [31:0] data_q[$];
    logic        last_q[$];
    int          hs_cyc_q[$];
    int          done_cnt = 0, done_cyc = -1, busy_cnt = 0;
    int          iss = 0, pops = 0, max_out = 0, stab_err = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic        prev_last = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            iss        <= 0;
            pops       <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (bram_en) begin
                addr_q.push_back(bram_addr);
                addr_cyc_q.push_back(cyc);
            end
            if (m_valid && m_ready) begin
                data_q.push_back(m_data);
                last_q.push_back(m_last);
                hs_cyc_q.push_back(cyc);
            end
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
                stab_err <= stab_err + 1;
            iss  <= iss + (bram_en ? 1 : 0);
            pops <= pops + ((m_valid && m_ready) ? 1 : 0);
            if ((iss + (bram_en ? 1 : 0)) - (pops + ((m_valid && m_ready) ? 1 : 0)) > max_out)
                max_out <= (iss + (bram_en ? 1 : 0)) - (pops + ((m_valid && m_ready) ? 1 : 0));
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (busy) busy_cnt <= busy_cnt + 1;
            prev_stall <= m_valid && !m_ready;
            prev_data  <= m_data;
            prev_last  <= m_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [15:0] l, output int s0);
        base_addr = b;
        len       = l;
        start     = 1'b1;
        s0        = cyc;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int d0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(); step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
        n_checks++; if (bram_en !== 1'b0) begin n_fail++; $display("FAIL reset_bram_en: got %0b want 0", bram_en); end
        n_checks++; if (bram_addr !== 32'd0) begin n_fail++; $display("FAIL reset_bram_addr: got %0h want 0", bram_addr); end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %0b want 0", m_valid); end
        n_checks++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %0b want 0", m_last); end
        n_checks++; if (bram_wen !== 4'b0000) begin n_fail++; $display("FAIL reset_bram_wen: got %0h want 0", bram_wen); end
        n_checks++; if (bram_din !== 32'd0) begin n_fail++; $display("FAIL reset_bram_din: got %0h want 0", bram_din); end
        @(negedge clk);
        rst = 1'b1;
        step(); step();
        n_checks++; if (busy !== 1'b0 || m_valid !== 1'b0 || bram_en !== 1'b0)
            begin n_fail++; $display("FAIL idle_after_reset: busy=%0b m_valid=%0b bram_en=%0b want 0/0/0", busy, m_valid, bram_en); end
    endtask

    task automatic test_basic();
        int s0, a0, d0, dn0;
        bit ok;
        a0 = addr_q.size(); d0 = data_q.size(); dn0 = done_cnt;
        m_ready = 1'b1;
        pulse_start(32'h40, 16'd8, s0);
        wait_done(60, dn0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: no done within 60 cycles"); end
        step(); step();
        n_checks++; if (addr_q.size() - a0 != 8) begin n_fail++; $display("FAIL basic_addr_count: got %0d want 8", addr_q.size() - a0); end
        for (int k = 0; k < 8 && a0 + k < addr_q.size(); k++) begin
            n_checks++; if (addr_q[a0 + k] !== 32'h40 + 32'(4 * k))
                begin n_fail++; $display("FAIL basic_addr[%0d]: got %0h want %0h", k, addr_q[a0 + k], 32'h40 + 32'(4 * k)); end
        end
        n_checks++; if (addr_q.size() > a0 && addr_cyc_q[a0] != s0 + 1)
            begin n_fail++; $display("FAIL basic_en_latency: got %0d want %0d", addr_cyc_q[a0] - s0, 1); end
        n_checks++; if (data_q.size() - d0 != 8) begin n_fail++; $display("FAIL basic_data_count: got %0d want 8", data_q.size() - d0); end
        for (int k = 0; k < 8 && d0 + k < data_q.size(); k++) begin
            n_checks++; if (data_q[d0 + k] !== 32'(48 + 3 * k) || last_q[d0 + k] !== (k == 7))
                begin n_fail++; $display("FAIL basic_word[%0d]: got %0d last %0b want %0d last %0b", k, data_q[d0 + k], last_q[d0 + k], 48 + 3 * k, k == 7); end
        end
        if (data_q.size() - d0 == 8) begin
            n_checks++; if (hs_cyc_q[d0] != s0 + 3)
                begin n_fail++; $display("FAIL basic_valid_latency: got %0d want 3", hs_cyc_q[d0] - s0); end
            n_checks++; if (hs_cyc_q[d0 + 7] - hs_cyc_q[d0] != 7)
                begin n_fail++; $display("FAIL basic_throughput: got %0d cycles want 7", hs_cyc_q[d0 + 7] - hs_cyc_q[d0]); end
            n_checks++; if (done_cyc != hs_cyc_q[d0 + 7] + 1)
                begin n_fail++; $display("FAIL basic_done_timing: got %0d want %0d", done_cyc, hs_cyc_q[d0 + 7] + 1); end
        end
        n_checks++; if (done_cnt - dn0 != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - dn0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %0b want 0", busy); end
    endtask

    task automatic test_len_zero();
        int s0, a0, d0, dn0, b0;
        a0 = addr_q.size(); d0 = data_q.size(); dn0 = done_cnt; b0 = busy_cnt;
        pulse_start(32'h80, 16'd0, s0);
        for (int i = 0; i < 6; i++) step();
        n_checks++; if (addr_q.size() != a0) begin n_fail++; $display("FAIL zero_no_bram_en: got %0d reads want 0", addr_q.size() - a0); end
        n_checks++; if (data_q.size() != d0) begin n_fail++; $display("FAIL zero_no_data: got %0d words want 0", data_q.size() - d0); end
        n_checks++; if (done_cnt - dn0 != 1) begin n_fail++; $display("FAIL zero_done_count: got %0d want 1", done_cnt - dn0); end
        n_checks++; if (done_cyc != s0 + 1) begin n_fail++; $display("FAIL zero_done_timing: got %0d want %0d", done_cyc - s0, 1); end
        n_checks++; if (busy_cnt - b0 != 1) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d want 1", busy_cnt - b0); end
    endtask

    task automatic test_backpressure();
        int s0, a0, d0, dn0, nlast;
        bit ok;
        a0 = addr_q.size(); d0 = data_q.size(); dn0 = done_cnt;
        m_ready = 1'b1;
        pulse_start(32'h40, 16'd16, s0);
        for (int i = 0; i < 26; i++) begin
            m_ready = (i < 16) ? (i % 2 == 0) : 1'b0;
            step();
        end
        m_ready = 1'b1;
        wait_done(80, dn0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: no done within 80 cycles"); end
        step();
        n_checks++; if (max_out > 4) begin n_fail++; $display("FAIL bp_buffered: got %0d outstanding want <=4", max_out); end
        n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stab_err); end
        n_checks++; if (addr_q.size() - a0 != 16) begin n_fail++; $display("FAIL bp_reads: got %0d want 16", addr_q.size() - a0); end
        n_checks++; if (data_q.size() - d0 != 16) begin n_fail++; $display("FAIL bp_words: got %0d want 16", data_q.size() - d0); end
        nlast = 0;
        for (int k = 0; k < 16 && d0 + k < data_q.size(); k++) begin
            nlast += last_q[d0 + k] ? 1 : 0;
            n_checks++; if (data_q[d0 + k] !== 32'(48 + 3 * k))
                begin n_fail++; $display("FAIL bp_data[%0d]: got %0d want %0d", k, data_q[d0 + k], 48 + 3 * k); end
        end
        n_checks++; if (nlast != 1 || data_q.size() - d0 != 16 || last_q[d0 + 15] !== 1'b1)
            begin n_fail++; $display("FAIL bp_last: got %0d last flags want 1 on word 15", nlast); end
        n_checks++; if (done_cnt - dn0 != 1) begin n_fail++; $display("FAIL bp_done_count: got %0d want 1", done_cnt - dn0); end
    endtask

    task automatic test_restart_ignored();
        int s0, s1, a0, d0, dn0;
        bit ok;
        a0 = addr_q.size(); d0 = data_q.size(); dn0 = done_cnt;
        m_ready = 1'b1;
        pulse_start(32'h40, 16'd5, s0);
        step(); step();
        pulse_start(32'h0, 16'd9, s1);
        wait_done(60, dn0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL restart_timeout: no done within 60 cycles"); end
        for (int i = 0; i < 8; i++) step();
        n_checks++; if (addr_q.size() - a0 != 5) begin n_fail++; $display("FAIL restart_reads: got %0d want 5", addr_q.size() - a0); end
        n_checks++; if (data_q.size() - d0 != 5) begin n_fail++; $display("FAIL restart_words: got %0d want 5", data_q.size() - d0); end
        for (int k = 0; k < 5 && d0 + k < data_q.size(); k++) begin
            n_checks++; if (data_q[d0 + k] !== 32'(48 + 3 * k) || last_q[d0 + k] !== (k == 4))
                begin n_fail++; $display("FAIL restart_word[%0d]: got %0d last %0b want %0d last %0b", k, data_q[d0 + k], last_q[d0 + k], 48 + 3 * k, k == 4); end
        end
        n_checks++; if (done_cnt - dn0 != 1) begin n_fail++; $display("FAIL restart_done_count: got %0d want 1", done_cnt - dn0); end
    endtask

    task automatic test_reset_mid();
        int s0, d0, d1, a1, dn0;
        bit ok;
        d0 = data_q.size();
        m_ready = 1'b1;
        pulse_start(32'h40, 16'd8, s0);
        for (int i = 0; i < 20 && data_q.size() - d0 < 3; i++) step();
        n_checks++; if (busy !== 1'b1 || data_q.size() - d0 != 3)
            begin n_fail++; $display("FAIL mid_precond: busy=%0b words=%0d want 1/3", busy, data_q.size() - d0); end
        rst = 1'b0;
        step();
        n_checks++; if ({busy, done, bram_en, m_valid, m_last} !== 5'b00000 || bram_addr !== 32'd0)
            begin n_fail++; $display("FAIL mid_reset_outputs: busy/done/en/valid/last=%05b addr=%0h want 00000/0", {busy, done, bram_en, m_valid, m_last}, bram_addr); end
        @(negedge clk);
        rst = 1'b1;
        d1 = data_q.size(); a1 = addr_q.size();
        for (int i = 0; i < 4; i++) step();
        n_checks++; if (data_q.size() != d1 || addr_q.size() != a1 || m_valid !== 1'b0)
            begin n_fail++; $display("FAIL mid_no_stale: got %0d words %0d reads want 0/0", data_q.size() - d1, addr_q.size() - a1); end
        dn0 = done_cnt;
        pulse_start(32'h40, 16'd2, s0);
        wait_done(40, dn0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_timeout: no done within 40 cycles"); end
        step();
        n_checks++; if (data_q.size() - d1 != 2) begin n_fail++; $display("FAIL mid_words: got %0d want 2", data_q.size() - d1); end
        for (int k = 0; k < 2 && d1 + k < data_q.size(); k++) begin
            n_checks++; if (data_q[d1 + k] !== 32'(48 + 3 * k) || last_q[d1 + k] !== (k == 1))
                begin n_fail++; $display("FAIL mid_word[%0d]: got %0d last %0b want %0d last %0b", k, data_q[d1 + k], last_q[d1 + k], 48 + 3 * k, k == 1); end
        end
        n_checks++; if (done_cnt - dn0 != 1) begin n_fail++; $display("FAIL mid_done_count: got %0d want 1", done_cnt - dn0); end
    endtask

`ifdef BRAM_RD_STRIDE_EN
    task automatic test_stride();
        int s0, a0, d0, dn0;
        bit ok;
        logic [31:0] exp_addr [4];
        exp_addr[0] = 32'h00; exp_addr[1] = 32'h0C; exp_addr[2] = 32'h18; exp_addr[3] = 32'h24;
        a0 = addr_q.size(); d0 = data_q.size(); dn0 = done_cnt;
        m_ready = 1'b1;
        stride  = 16'd3;
        pulse_start(32'h0, 16'd4, s0);
        stride  = 16'd1;
        wait_done(40, dn0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stride_timeout: no done within 40 cycles"); end
        n_checks++; if (addr_q.size() - a0 != 4 || data_q.size() - d0 != 4)
            begin n_fail++; $display("FAIL stride_count: got %0d reads %0d words want 4/4", addr_q.size() - a0, data_q.size() - d0); end
        for (int k = 0; k < 4 && a0 + k < addr_q.size() && d0 + k < data_q.size(); k++) begin
            n_checks++; if (addr_q[a0 + k] !== exp_addr[k] || data_q[d0 + k] !== 32'(9 * k))
                begin n_fail++; $display("FAIL stride[%0d]: got addr %0h data %0d want %0h %0d", k, addr_q[a0 + k], data_q[d0 + k], exp_addr[k], 9 * k); end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'(i * 3);
        test_reset();
        test_basic();
        test_len_zero();
        test_backpressure();
        test_restart_ignored();
        test_reset_mid();
`ifdef BRAM_RD_STRIDE_EN
        test_stride();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
